// File: rtl/imem_prefetch_queue.sv
// Instruction prefetch FIFO with an integrated instruction register for the multicycle i281.
// Fetched words queue up with their PC; the IR-load strobe pops the oldest into the IR.
module imem_prefetch_queue #(
  parameter int WIDTH    = 16,
  parameter int PC_WIDTH = 6,
  parameter int DEPTH    = 4,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic                push,
  input  logic [WIDTH-1:0]    instruction,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                ir_load,
  input  logic                flush,
  output logic [WIDTH-1:0]    imem_register,
  output logic [PC_WIDTH-1:0] ir_pc,
  output logic                ir_valid,
  output logic                full,
  output logic                empty,
  output logic [CW-1:0]       count,
  output logic                overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]    word_q [DEPTH];
  logic [PC_WIDTH-1:0] tag_q  [DEPTH];

  logic [PW-1:0]       rptr_q, wptr_q;
  logic [CW-1:0]       count_q;
  logic [WIDTH-1:0]    ir_q;
  logic [PC_WIDTH-1:0] ir_pc_q;
  logic                ir_valid_q;
  logic                overflow_q;

  logic q_empty, q_full;
  logic eff_pop, eff_push;
  logic deq, enq, bypass, drop;

  always_comb begin
    q_empty  = (count_q == '0);
    q_full   = (count_q == CW'(DEPTH));
    eff_pop  = ir_load & (!q_empty | push);
    eff_push = push & (!q_full | ir_load);
    // On an empty queue a pop can only be satisfied by the word arriving this cycle.
    bypass   = eff_pop & q_empty;
    deq      = eff_pop & !q_empty;
    enq      = eff_push & !bypass;
    drop     = push & !eff_push;
  end

  // Entry storage needs no reset: pointers and count define which slots are live.
  always_ff @(posedge clock) begin
    if (reset && run) begin
      if (flush) begin
        if (push) begin
          word_q[0] <= instruction;
          tag_q[0]  <= pc;
        end
      end else if (enq) begin
        word_q[wptr_q] <= instruction;
        tag_q[wptr_q]  <= pc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else if (run) begin
      if (flush) begin
        // Only the branch-target push survives a flush; the IR is left alone.
        rptr_q  <= '0;
        wptr_q  <= push ? PW'(1) : '0;
        count_q <= push ? CW'(1) : '0;
      end else begin
        if (deq) begin
          ir_q       <= word_q[rptr_q];
          ir_pc_q    <= tag_q[rptr_q];
          ir_valid_q <= 1'b1;
          rptr_q     <= rptr_q + PW'(1);
        end else if (bypass) begin
          ir_q       <= instruction;
          ir_pc_q    <= pc;
          ir_valid_q <= 1'b1;
        end else if (ir_load) begin
          ir_valid_q <= 1'b0;
        end

        if (enq) begin
          wptr_q <= wptr_q + PW'(1);
        end

        if (enq && !deq) begin
          count_q <= count_q + CW'(1);
        end else if (deq && !enq) begin
          count_q <= count_q - CW'(1);
        end

        if (drop) begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  assign imem_register = ir_q;
  assign ir_pc         = ir_pc_q;
  assign ir_valid      = ir_valid_q;
  assign count         = count_q;
  assign full          = q_full;
  assign empty         = q_empty;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_imem_prefetch_queue.sv
// Bench for imem_prefetch_queue: DEPTH=4 and DEPTH=8 instances share stimulus and are checked
// against a queue-based reference model, plus a hand-computed vector table for the DEPTH=4 one.
module tb_imem_prefetch_queue;

  localparam int W = 16;
  localparam int P = 6;

  logic         clock;
  logic         reset;
  logic         run;
  logic         push;
  logic [W-1:0] instruction;
  logic [P-1:0] pc;
  logic         ir_load;
  logic         flush;

  logic [W-1:0] o_ir    [2];
  logic [P-1:0] o_pc    [2];
  logic         o_v     [2];
  logic         o_full  [2];
  logic         o_empty [2];
  logic         o_ovf   [2];
  logic [2:0]   cnt4;
  logic [3:0]   cnt8;

  imem_prefetch_queue #(.WIDTH(W), .PC_WIDTH(P), .DEPTH(4)) dut4 (
    .clock(clock), .reset(reset), .run(run), .push(push), .instruction(instruction), .pc(pc),
    .ir_load(ir_load), .flush(flush), .imem_register(o_ir[0]), .ir_pc(o_pc[0]),
    .ir_valid(o_v[0]), .full(o_full[0]), .empty(o_empty[0]), .count(cnt4), .overflow(o_ovf[0])
  );

  imem_prefetch_queue #(.WIDTH(W), .PC_WIDTH(P), .DEPTH(8)) dut8 (
    .clock(clock), .reset(reset), .run(run), .push(push), .instruction(instruction), .pc(pc),
    .ir_load(ir_load), .flush(flush), .imem_register(o_ir[1]), .ir_pc(o_pc[1]),
    .ir_valid(o_v[1]), .full(o_full[1]), .empty(o_empty[1]), .count(cnt8), .overflow(o_ovf[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one scoreboard queue of {pc, word} per instance.
  logic [P+W-1:0] mq [2][$];
  logic [W-1:0]   m_ir  [2];
  logic [P-1:0]   m_pc  [2];
  logic           m_v   [2];
  logic           m_ovf [2];

  typedef struct {
    logic rst_n, run, push, ld, fl;
    logic [W-1:0] ins;
    logic [P-1:0] pcv;
    logic [W-1:0] e_ir;
    logic [P-1:0] e_pc;
    logic e_v;
    int   e_cnt;
    logic e_full, e_ovf;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(logic r, logic rn, logic ps, logic ld, logic fl, logic [W-1:0] ins,
                              logic [P-1:0] pcv, logic [W-1:0] eir, logic [P-1:0] epc,
                              logic ev, int ecnt, logic efull, logic eovf);
    vec_t v;
    v.rst_n = r; v.run = rn; v.push = ps; v.ld = ld; v.fl = fl; v.ins = ins; v.pcv = pcv;
    v.e_ir = eir; v.e_pc = epc; v.e_v = ev; v.e_cnt = ecnt; v.e_full = efull; v.e_ovf = eovf;
    return v;
  endfunction

  function automatic int depth_of(int k);
    return (k == 0) ? 4 : 8;
  endfunction

  function automatic int count_of(int k);
    return (k == 0) ? int'(cnt4) : int'(cnt8);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    logic [P+W-1:0] e;
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        mq[k].delete();
        m_ir[k] = '0; m_pc[k] = '0; m_v[k] = 1'b0; m_ovf[k] = 1'b0;
      end else if (run) begin
        if (flush) begin
          mq[k].delete();
          if (push) mq[k].push_back({pc, instruction});
        end else if (ir_load) begin
          if (mq[k].size() > 0) begin
            e = mq[k].pop_front();
            m_ir[k] = e[W-1:0]; m_pc[k] = e[P+W-1:W]; m_v[k] = 1'b1;
            if (push) mq[k].push_back({pc, instruction});
          end else if (push) begin
            m_ir[k] = instruction; m_pc[k] = pc; m_v[k] = 1'b1;
          end else begin
            m_v[k] = 1'b0;
          end
        end else if (push) begin
          if (mq[k].size() == depth_of(k)) m_ovf[k] = 1'b1;
          else mq[k].push_back({pc, instruction});
        end
      end
    end
  endtask

  task automatic check_model(string tag);
    for (int k = 0; k < 2; k++) begin
      int sz = mq[k].size();
      int d  = depth_of(k);
      chk($sformatf("%s d%0d ir", tag, d), 32'(o_ir[k]), 32'(m_ir[k]));
      chk($sformatf("%s d%0d ir_pc", tag, d), 32'(o_pc[k]), 32'(m_pc[k]));
      chk($sformatf("%s d%0d ir_valid", tag, d), 32'(o_v[k]), 32'(m_v[k]));
      chk($sformatf("%s d%0d count", tag, d), 32'(count_of(k)), 32'(sz));
      chk($sformatf("%s d%0d full", tag, d), 32'(o_full[k]), 32'(sz == d));
      chk($sformatf("%s d%0d empty", tag, d), 32'(o_empty[k]), 32'(sz == 0));
      chk($sformatf("%s d%0d overflow", tag, d), 32'(o_ovf[k]), 32'(m_ovf[k]));
      chk($sformatf("%s d%0d count bound", tag, d), 32'(count_of(k) <= d), 32'd1);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; run = 1'b1; push = 1'b0; ir_load = 1'b0; flush = 1'b0;
    instruction = '0; pc = '0;
    for (int k = 0; k < 2; k++) begin
      m_ir[k] = '0; m_pc[k] = '0; m_v[k] = 1'b0; m_ovf[k] = 1'b0;
    end

    // Expected values are for the DEPTH=4 instance.
    tbl[0]  = mk(0, 1, 0, 0, 0, 16'h0000, 0,  16'h0000, 0,  0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 1, 0, 0, 16'h1001, 1,  16'h0000, 0,  0, 1, 0, 0);
    tbl[2]  = mk(1, 1, 1, 0, 0, 16'h1002, 2,  16'h0000, 0,  0, 2, 0, 0);
    tbl[3]  = mk(1, 1, 1, 0, 0, 16'h1003, 3,  16'h0000, 0,  0, 3, 0, 0);
    tbl[4]  = mk(1, 1, 1, 0, 0, 16'h1004, 4,  16'h0000, 0,  0, 4, 1, 0);
    tbl[5]  = mk(1, 1, 1, 0, 0, 16'hDEAD, 5,  16'h0000, 0,  0, 4, 1, 1);
    tbl[6]  = mk(1, 1, 1, 1, 0, 16'hBEEF, 6,  16'h1001, 1,  1, 4, 1, 1);
    tbl[7]  = mk(1, 1, 0, 1, 0, 16'h0000, 0,  16'h1002, 2,  1, 3, 0, 1);
    tbl[8]  = mk(1, 1, 0, 1, 0, 16'h0000, 0,  16'h1003, 3,  1, 2, 0, 1);
    tbl[9]  = mk(1, 1, 0, 1, 0, 16'h0000, 0,  16'h1004, 4,  1, 1, 0, 1);
    tbl[10] = mk(1, 1, 0, 1, 0, 16'h0000, 0,  16'hBEEF, 6,  1, 0, 0, 1);
    tbl[11] = mk(1, 1, 1, 1, 0, 16'h2222, 9,  16'h2222, 9,  1, 0, 0, 1);
    tbl[12] = mk(1, 1, 0, 1, 0, 16'h0000, 0,  16'h2222, 9,  0, 0, 0, 1);
    tbl[13] = mk(1, 1, 1, 0, 0, 16'h0A01, 10, 16'h2222, 9,  0, 1, 0, 1);
    tbl[14] = mk(1, 1, 1, 0, 0, 16'h0A02, 11, 16'h2222, 9,  0, 2, 0, 1);
    tbl[15] = mk(1, 1, 1, 0, 0, 16'h0A03, 12, 16'h2222, 9,  0, 3, 0, 1);
    tbl[16] = mk(1, 1, 1, 1, 1, 16'h3333, 20, 16'h2222, 9,  0, 1, 0, 1);
    tbl[17] = mk(1, 1, 0, 1, 0, 16'h0000, 0,  16'h3333, 20, 1, 0, 0, 1);
    tbl[18] = mk(1, 0, 1, 1, 1, 16'h4444, 30, 16'h3333, 20, 1, 0, 0, 1);
    tbl[19] = mk(1, 0, 1, 1, 0, 16'h5555, 31, 16'h3333, 20, 1, 0, 0, 1);
    tbl[20] = mk(1, 0, 0, 0, 1, 16'h0000, 0,  16'h3333, 20, 1, 0, 0, 1);
    tbl[21] = mk(1, 0, 1, 0, 0, 16'h7777, 32, 16'h3333, 20, 1, 0, 0, 1);
    tbl[22] = mk(1, 0, 0, 1, 0, 16'h0000, 0,  16'h3333, 20, 1, 0, 0, 1);
    tbl[23] = mk(0, 0, 1, 1, 1, 16'h6666, 33, 16'h0000, 0,  0, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      reset = tbl[i].rst_n; run = tbl[i].run; push = tbl[i].push;
      ir_load = tbl[i].ld; flush = tbl[i].fl;
      instruction = tbl[i].ins; pc = tbl[i].pcv;
      step();
      chk($sformatf("vec%0d ir", i), 32'(o_ir[0]), 32'(tbl[i].e_ir));
      chk($sformatf("vec%0d ir_pc", i), 32'(o_pc[0]), 32'(tbl[i].e_pc));
      chk($sformatf("vec%0d ir_valid", i), 32'(o_v[0]), 32'(tbl[i].e_v));
      chk($sformatf("vec%0d count", i), 32'(cnt4), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d full", i), 32'(o_full[0]), 32'(tbl[i].e_full));
      chk($sformatf("vec%0d empty", i), 32'(o_empty[0]), 32'(tbl[i].e_cnt == 0));
      chk($sformatf("vec%0d overflow", i), 32'(o_ovf[0]), 32'(tbl[i].e_ovf));
      check_model($sformatf("vec%0d", i));
    end

    // Mid-stream freeze: fill partly, stall with toggling controls, then drain.
    reset = 1'b1; run = 1'b1; flush = 1'b0; ir_load = 1'b0; push = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instruction = 16'hC000 + 16'(i); pc = 6'(40 + i);
      step();
      check_model($sformatf("fill%0d", i));
    end
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push = i[0]; ir_load = ~i[0]; flush = i[1];
      step();
      check_model($sformatf("freeze%0d", i));
    end
    run = 1'b1; push = 1'b0; flush = 1'b0; ir_load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_model($sformatf("drain%0d", i));
    end

    // Random mix including occasional freezes and resets.
    for (int i = 0; i < 2000; i++) begin
      reset       = ($urandom_range(0, 199) != 0);
      run         = ($urandom_range(0, 19) != 0);
      push        = ($urandom_range(0, 99) < 55);
      ir_load     = ($urandom_range(0, 99) < 45);
      flush       = ($urandom_range(0, 99) < 5);
      instruction = W'($urandom);
      pc          = P'($urandom);
      step();
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_prefetch_queue.md
# imem_prefetch_queue

Parametrised instruction prefetch queue with an integrated instruction register for the multicycle i281 datapath. It sits between code memory and the control unit. Fetched words are pushed together with their PC into a DEPTH-entry FIFO. The control unit's IR-load strobe pops the oldest entry into the instruction register. A flush input discards prefetched words on a taken branch. A global run input freezes the whole block.

## Interface
- WIDTH, 16: instruction word width.
- PC_WIDTH, 6: width of the PC tag stored with each word.
- DEPTH, 4: number of queue entries; must be a power of two, ≥2.
- CW = $clog2(DEPTH+1): width of count.
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- run  in  1  global enable; when 0, no state changes except reset.
- push  in  1  write instruction/pc into the queue.
- instruction  in  WIDTH  word from code memory.
- pc  in  PC_WIDTH  address of instruction.
- ir_load  in  1  pop the head into the IR (successor of the c16 load strobe).
- flush  in  1  discard all queued entries (taken branch).
- imem_register  out  WIDTH  instruction register.
- ir_pc  out  PC_WIDTH  PC of the word in imem_register.
- ir_valid  out  1  imem_register holds a real instruction (0 = bubble).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  CW  occupied entries.
- overflow  out  1  sticky: a push was dropped.

## Operation
- Reset (reset == 0 at an edge) sets the following, regardless of run or any other input:
  - read pointer, write pointer and count to 0;
  - imem_register, ir_pc and ir_valid to 0;
  - overflow to 0.
- After reset, empty = 1 and full = 0.
- All actions below require run == 1. With run == 0, every register holds.
- Define `eff_pop = ir_load & (!empty | push)` and `eff_push = push & (!full | ir_load)`.
- Pointers wrap modulo DEPTH. count changes by +1, -1 or 0 per edge and never exceeds DEPTH.
- flush == 1 takes priority:
  - pointers and count go to 0;
  - ir_load is ignored; IR and ir_valid hold;
  - a simultaneous push is accepted as the sole entry (the branch target), giving count = 1;
  - a push during flush is never dropped.
- ir_load with a non-empty queue: the head entry moves into imem_register/ir_pc, ir_valid ← 1, and the read pointer advances.
- ir_load, empty queue, push == 1 (bypass): instruction/pc go directly into the IR, ir_valid ← 1, and count stays 0.
- ir_load, empty queue, push == 0: imem_register/ir_pc hold and ir_valid ← 0 (bubble).
- push while full:
  - with ir_load == 1 (and no flush): accepted, because the pop frees a slot; count stays DEPTH.
  - with ir_load == 0: the word is dropped, overflow ← 1, and the queue is unchanged.
- push and ir_load both set on a non-empty, non-full queue: the head is popped, the new word is enqueued at the tail, and count is unchanged.
- full, empty and count are decoded from registered count only. There is no combinational path from push, ir_load or flush to any output.

## Timing
- All outputs are registered and update on the same edge as the causing action.
- Latency from a push at edge n to the word in the IR:
  - 0 cycles via bypass (the IR shows the word after edge n);
  - otherwise the first ir_load edge after n, once the word reaches the head.
- Entries leave the queue strictly in FIFO order. Across a flush, only the flush-cycle push survives.
- A reset asserted mid-stream discards the queue and the IR at that edge. run has no effect while reset == 0.
- Deasserting run mid-stream freezes pointers, IR and flags exactly. Operation resumes unchanged on the next edge with run == 1.

## Test plan
- Reset, then push 0x1001..0x1004 (pc 1..4) on 4 edges: full = 1, count = 4. Then 4× ir_load: IR = 0x1001..0x1004 in order, ir_pc 1..4, ending with empty = 1.
- On the full queue, push 0xDEAD with ir_load = 0: overflow = 1, count = 4, and later pops never show 0xDEAD. On the full queue, push 0xBEEF with ir_load = 1: IR = 0x1001, count = 4, and 0xBEEF is popped last.
- Empty queue, push 0x2222 (pc 9) with ir_load in the same cycle: IR = 0x2222 and ir_pc = 9 after that edge, ir_valid = 1, count = 0. A following ir_load with no push gives ir_valid = 0 with IR still 0x2222.
- Queue holding 3 entries, flush with push 0x3333 (pc 20) and ir_load = 1: IR unchanged, count = 1. The next ir_load gives IR = 0x3333, ir_pc = 20.
- run = 0 for 5 cycles while push/ir_load/flush toggle: all outputs hold. Asserting reset = 0 with run = 0 still clears everything on the next edge.
- Random push/ir_load/flush mix for 2000 cycles, DEPTH = 8: outputs match a reference queue model. count never exceeds 8, and pointers wrap with no loss or duplication.
